// File: rtl/misao_pkg.sv
// Shared types and helpers for the MISA-O nibble-to-byte memory bridge.
package misao_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SERVE,
      CAPTURE,
      WRITE
   } state_t;

   localparam logic NIB_LO = 1'b0;
   localparam logic NIB_HI = 1'b1;

   function automatic logic [7:0] merge_nib(input logic [7:0] byte_in,
                                            input logic [3:0] nib,
                                            input logic       sel);
      return (sel == NIB_HI) ? {nib, byte_in[3:0]} : {byte_in[7:4], nib};
   endfunction

   function automatic logic [3:0] sel_nib(input logic [7:0] byte_in,
                                          input logic       sel);
      return (sel == NIB_LO) ? byte_in[3:0] : byte_in[7:4];
   endfunction

endpackage

// File: rtl/misao_line_buf.sv
// One-byte line buffer: tag/data/valid with fill, nibble merge and invalidate.
module misao_line_buf
   import misao_pkg::*;
#(
   parameter int TAG_W = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             hit,
   output logic [7:0]       line_data,
   input  logic             fill_en,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic [7:0]       fill_data,
   input  logic             merge_en,
   input  logic [3:0]       merge_data,
   input  logic             merge_sel,
   input  logic             drop,
   input  logic             line_inv
);

   logic [TAG_W-1:0] tag_q;
   logic             valid_q;

   assign hit = valid_q && (tag_q == lookup_tag);

   // Data and tag still update under an invalidate so a pending access can finish.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q     <= '0;
         line_data <= '0;
         valid_q   <= 1'b0;
      end else begin
         if (fill_en) begin
            tag_q     <= fill_tag;
            line_data <= fill_data;
         end else if (merge_en) begin
            line_data <= merge_nib(line_data, merge_data, merge_sel);
         end
         if (line_inv || drop)
            valid_q <= 1'b0;
         else if (fill_en)
            valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/misao_nibble_bridge.sv
// Bridges the MISA-O nibble memory port onto a byte-wide variable-latency RAM.
//
// state   | meaning
// IDLE    | sample core request, decide hit/miss
// FETCH   | RAM read of the addressed byte, wait for ack or timeout
// SERVE   | core_rd_valid pulse with the selected nibble
// CAPTURE | core_wr_en pulse, merge core_wdata into the line
// WRITE   | write-through of the merged byte, wait for ack or timeout
module misao_nibble_bridge
   import misao_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_rw,
   input  logic [3:0]        core_wdata,
   output logic [3:0]        core_rdata,
   output logic              core_rd_valid,
   output logic              core_wr_en,
   output logic [ADDR_W-2:0] ram_addr,
   output logic              ram_req,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              ram_ack,
   input  logic              line_inv,
   output logic              err
);

   localparam int             TMO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              req_rw_q, req_rw_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   logic [3:0]        rdata_d;
   logic              rd_valid_d, wr_en_d, req_d, we_d, err_d;
   logic [ADDR_W-2:0] raddr_d;
   logic [7:0]        wdata_d;

   logic              hit, fill_en, merge_en, drop;
   logic [7:0]        line_data;
   logic              acked, tmo_hit;

   assign acked   = ram_req && ram_ack;
   assign tmo_hit = ram_req && !ram_ack && (tmo_q == '0);

   misao_line_buf #(.TAG_W(ADDR_W-1)) u_line (
      .clk        (clk),
      .rst        (rst),
      .lookup_tag (core_addr[ADDR_W-1:1]),
      .hit        (hit),
      .line_data  (line_data),
      .fill_en    (fill_en),
      .fill_tag   (req_addr_q[ADDR_W-1:1]),
      .fill_data  (ram_rdata),
      .merge_en   (merge_en),
      .merge_data (core_wdata),
      .merge_sel  (req_addr_q[0]),
      .drop       (drop),
      .line_inv   (line_inv)
   );

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      req_rw_d   = req_rw_q;
      tmo_d      = tmo_q;
      rdata_d    = core_rdata;
      rd_valid_d = 1'b0;
      wr_en_d    = 1'b0;
      req_d      = ram_req;
      we_d       = ram_we;
      raddr_d    = ram_addr;
      wdata_d    = ram_wdata;
      err_d      = err;
      fill_en    = 1'b0;
      merge_en   = 1'b0;
      drop       = 1'b0;

      case (state_q)
         IDLE: begin
            req_addr_d = core_addr;
            req_rw_d   = core_rw;
            if (hit && core_rw) begin
               state_d    = SERVE;
               rd_valid_d = 1'b1;
               rdata_d    = sel_nib(line_data, core_addr[0]);
            end else if (hit) begin
               state_d = CAPTURE;
               wr_en_d = 1'b1;
            end else begin
               state_d = FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               raddr_d = core_addr[ADDR_W-1:1];
               tmo_d   = TMO_LOAD;
            end
         end
         FETCH: begin
            if (acked) begin
               fill_en = 1'b1;
               req_d   = 1'b0;
               if (req_rw_q) begin
                  state_d    = SERVE;
                  rd_valid_d = 1'b1;
                  rdata_d    = sel_nib(ram_rdata, req_addr_q[0]);
               end else begin
                  state_d = CAPTURE;
                  wr_en_d = 1'b1;
               end
            end else if (tmo_hit) begin
               req_d = 1'b0;
               err_d = 1'b1;
               drop  = 1'b1;
               if (req_rw_q) begin
                  state_d    = SERVE;
                  rd_valid_d = 1'b1;
                  rdata_d    = 4'hF;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         SERVE: state_d = IDLE;
         CAPTURE: begin
            merge_en = 1'b1;
            wdata_d  = merge_nib(line_data, core_wdata, req_addr_q[0]);
            req_d    = 1'b1;
            we_d     = 1'b1;
            raddr_d  = req_addr_q[ADDR_W-1:1];
            tmo_d    = TMO_LOAD;
            state_d  = WRITE;
         end
         WRITE: begin
            if (acked || tmo_hit) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               if (!acked) begin
                  err_d = 1'b1;
                  drop  = 1'b1;
               end
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         req_addr_q    <= '0;
         req_rw_q      <= 1'b1;
         tmo_q         <= '0;
         core_rdata    <= '0;
         core_rd_valid <= 1'b0;
         core_wr_en    <= 1'b0;
         ram_addr      <= '0;
         ram_req       <= 1'b0;
         ram_we        <= 1'b0;
         ram_wdata     <= '0;
         err           <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         req_rw_q      <= req_rw_d;
         tmo_q         <= tmo_d;
         core_rdata    <= rdata_d;
         core_rd_valid <= rd_valid_d;
         core_wr_en    <= wr_en_d;
         ram_addr      <= raddr_d;
         ram_req       <= req_d;
         ram_we        <= we_d;
         ram_wdata     <= wdata_d;
         err           <= err_d;
      end
   end

endmodule

// File: tb/tb_misao_nibble_bridge.sv
// Randomized self-checking bench for misao_nibble_bridge against a line/RAM model.
module tb_misao_nibble_bridge;

   localparam int ADDR_W = 16;
   localparam int TMO    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic              core_rw = 1'b1;
   logic [3:0]        core_wdata = '0;
   logic [3:0]        core_rdata;
   logic              core_rd_valid, core_wr_en;
   logic [ADDR_W-2:0] ram_addr;
   logic              ram_req, ram_we;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata = '0;
   logic              ram_ack = 1'b0;
   logic              line_inv = 1'b0;
   logic              err;

   always #5 clk = ~clk;

   misao_nibble_bridge #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .core_addr(core_addr), .core_rw(core_rw),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_rd_valid(core_rd_valid),
      .core_wr_en(core_wr_en), .ram_addr(ram_addr), .ram_req(ram_req), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
      .line_inv(line_inv), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RAM contents and responder knobs
   logic [7:0]  mem [0:32767];
   int          ack_delay  = 1;
   bit          ack_never  = 1'b0;
   bit          stray      = 1'b0;
   bit          inv_on_ack = 1'b0;
   int          req_cnt = 0, n_bursts = 0, n_rd_ack = 0, n_wr_ack = 0, last_len = 0;
   logic [14:0] last_addr = '0;
   logic [7:0]  last_wdata = '0;
   bit          prev_req = 1'b0;

   // Behavioural line model
   bit          mv = 1'b0;
   logic [14:0] mtag = '0;
   bit          merr = 1'b0;

   initial begin : responder
      forever begin
         @(posedge clk); #1;
         ram_ack  = 1'b0;
         line_inv = 1'b0;
         if (ram_req) begin
            if (!prev_req) n_bursts++;
            req_cnt++;
            if (!ack_never && req_cnt == ack_delay) begin
               ram_ack   = 1'b1;
               last_addr = ram_addr;
               if (ram_we) begin
                  mem[ram_addr] = ram_wdata;
                  last_wdata    = ram_wdata;
                  n_wr_ack++;
               end else begin
                  ram_rdata = mem[ram_addr];
                  n_rd_ack++;
               end
               line_inv = inv_on_ack;
            end
         end else begin
            if (prev_req) last_len = req_cnt;
            req_cnt = 0;
            ram_ack = stray;
         end
         prev_req = ram_req;
      end
   end

   task automatic chk_reset_outs(input string tag);
      chk({tag, ":rdata"},    32'(core_rdata), 32'h0);
      chk({tag, ":rd_valid"}, 32'(core_rd_valid), 32'h0);
      chk({tag, ":wr_en"},    32'(core_wr_en), 32'h0);
      chk({tag, ":ram_req"},  32'(ram_req), 32'h0);
      chk({tag, ":ram_we"},   32'(ram_we), 32'h0);
      chk({tag, ":ram_addr"}, 32'(ram_addr), 32'h0);
      chk({tag, ":ram_wdata"},32'(ram_wdata), 32'h0);
      chk({tag, ":err"},      32'(err), 32'h0);
   endtask

   task automatic do_read(input logic [15:0] a, input string tag);
      bit         hit, tmo, got;
      int         b_rd, lat, exp_lat;
      logic [7:0] byt;
      logic [3:0] exp_nib;
      hit     = mv && (mtag == a[15:1]);
      tmo     = !hit && ack_never;
      b_rd    = n_rd_ack;
      byt     = mem[a[15:1]];
      exp_nib = a[0] ? byt[7:4] : byt[3:0];
      if (tmo) exp_nib = 4'hF;
      exp_lat = hit ? 1 : (tmo ? 1 + TMO : 1 + ack_delay);
      @(negedge clk);
      core_addr = a;
      core_rw   = 1'b1;
      lat = 0;
      got = 1'b0;
      while (lat < 64 && !got) begin
         @(posedge clk); #2;
         lat++;
         if (core_rd_valid) got = 1'b1;
      end
      chk({tag, ":strobe"}, 32'(got), 32'h1);
      if (got) begin
         chk({tag, ":latency"}, lat, exp_lat);
         chk({tag, ":rdata"}, 32'(core_rdata), 32'(exp_nib));
      end
      chk({tag, ":ram_reads"}, n_rd_ack - b_rd, (hit || tmo) ? 0 : 1);
      if (!hit) begin
         if (tmo) begin
            mv   = 1'b0;
            merr = 1'b1;
         end else begin
            mv   = !inv_on_ack;
            mtag = a[15:1];
         end
      end
      @(posedge clk); #2;
      chk({tag, ":one_cycle"}, 32'(core_rd_valid), 32'h0);
      chk({tag, ":err"}, 32'(err), 32'(merr));
   endtask

   task automatic do_write(input logic [15:0] a, input logic [3:0] nib, input string tag);
      bit         hit, got;
      int         b_rd, b_wr, lat, exp_lat, guard;
      logic [7:0] old, exp_b;
      hit     = mv && (mtag == a[15:1]);
      b_rd    = n_rd_ack;
      b_wr    = n_wr_ack;
      old     = mem[a[15:1]];
      exp_b   = a[0] ? {nib, old[3:0]} : {old[7:4], nib};
      exp_lat = hit ? 1 : 1 + ack_delay;
      @(negedge clk);
      core_addr  = a;
      core_rw    = 1'b0;
      core_wdata = nib;
      lat = 0;
      got = 1'b0;
      while (lat < 64 && !got) begin
         @(posedge clk); #2;
         lat++;
         if (core_wr_en) got = 1'b1;
      end
      chk({tag, ":wr_strobe"}, 32'(got), 32'h1);
      chk({tag, ":wr_latency"}, lat, exp_lat);
      chk({tag, ":ram_reads"}, n_rd_ack - b_rd, hit ? 0 : 1);
      guard = 0;
      do begin
         @(posedge clk); #2;
         guard++;
      end while (ram_req && guard < 64);
      chk({tag, ":req_released"}, 32'(ram_req), 32'h0);
      chk({tag, ":ram_writes"}, n_wr_ack - b_wr, 1);
      chk({tag, ":wr_addr"}, 32'(last_addr), 32'(a[15:1]));
      chk({tag, ":wr_byte"}, 32'(last_wdata), 32'(exp_b));
      chk({tag, ":err"}, 32'(err), 32'(merr));
      mv   = !inv_on_ack;
      mtag = a[15:1];
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin : main
      logic [14:0] bases [6];
      logic [15:0] a;
      int          b;
      bases = '{15'h0008, 15'h0010, 15'h0030, 15'h0080, 15'h0100, 15'h1234};
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      mem[15'h0008] = 8'hA5;
      mem[15'h0010] = 8'h3C;

      repeat (3) @(posedge clk);
      #2;
      chk_reset_outs("reset");
      rst = 1'b1;

      ack_delay = 3;
      b = n_bursts;
      do_read(16'h0010, "rd_0010");
      do_read(16'h0011, "rd_0011");
      chk("rd_pair:bursts", n_bursts - b, 1);

      ack_delay = 2;
      do_write(16'h0021, 4'h7, "wr_0021");
      chk("wr_0021:ram_byte", 32'(mem[15'h0010]), 32'h7C);
      do_read(16'h0020, "rd_0020");

      ack_never = 1'b1;
      do_read(16'h0100, "tmo_0100");
      chk("tmo_0100:req_len", last_len, TMO);
      ack_never = 1'b0;

      for (int i = 0; i < 40; i++) begin
         a          = {bases[$urandom_range(0, 5)], 1'($urandom)};
         ack_delay  = $urandom_range(1, TMO - 1);
         inv_on_ack = ($urandom_range(0, 7) == 0);
         stray      = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) do_read(a, "rnd_rd");
         else do_write(a, 4'($urandom), "rnd_wr");
      end
      inv_on_ack = 1'b0;
      stray      = 1'b0;

      mem[15'h0020] = 8'h12;
      ack_delay  = 2;
      inv_on_ack = 1'b1;
      do_read(16'h0040, "inv_0040");
      inv_on_ack = 1'b0;
      do_read(16'h0041, "inv_0041");

      stray     = 1'b1;
      ack_delay = 1;
      b = n_bursts;
      do_read(16'hFFFF, "rd_ffff");
      chk("rd_ffff:ram_addr", 32'(last_addr), 32'h7FFF);
      chk("rd_ffff:bursts", n_bursts - b, 1);
      stray = 1'b0;

      // Reset while a write-through is stalled waiting for ack
      do_read(16'h0010, "pre_rst");
      ack_never = 1'b1;
      @(negedge clk);
      core_addr  = 16'h0010;
      core_rw    = 1'b0;
      core_wdata = 4'h9;
      @(posedge clk); #2;
      chk("rst_wr:wr_en", 32'(core_wr_en), 32'h1);
      @(posedge clk); #2;
      chk("rst_wr:ram_req", 32'(ram_req), 32'h1);
      chk("rst_wr:ram_we", 32'(ram_we), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #2;
      chk_reset_outs("rst_mid");
      ack_never = 1'b0;
      core_rw   = 1'b1;
      @(posedge clk); #2;
      rst  = 1'b1;
      mv   = 1'b0;
      merr = 1'b0;
      ack_delay = 2;
      do_read(16'h0010, "post_rst");

      for (int i = 0; i < 10; i++) begin
         a         = {bases[$urandom_range(0, 5)], 1'($urandom)};
         ack_delay = $urandom_range(1, TMO - 1);
         if ($urandom_range(0, 1) == 1) do_read(a, "rnd2_rd");
         else do_write(a, 4'($urandom), "rnd2_wr");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
